// File: rtl/dcache_fill.sv
// Purpose: moves a dcache line to/from a nibble-serial RAM (write-back, then fill) as cmd/addr/data nibbles.
// Latency: 1 cmd + NA addr cycles per direction; fill data reaches the cache 1 cycle after each mem_in nibble.
// Backpressure: none on the memory side beyond the mem_rdy wait (bounded by TIMEOUT); the cache is strobed unconditionally.
//
// Ports:
//   clk, reset (async, active-low)
//   start/push/pull/tag      : miss request from the cache, sampled only in IDLE
//   dwrite, rstrobe_d        : write-back data out of the cache (offset advances per strobe)
//   dread, wstrobe_d         : fill data into the cache (registered)
//   busy, done, err          : status; done/err are single-cycle pulses
//   mem_sel/mem_oe/mem_out   : serial memory bus driven by this block
//   mem_in/mem_rdy           : serial memory read return
module dcache_fill #(
    parameter int         LINE_LENGTH = 4,
    parameter int         PA          = 22,
    parameter logic [3:0] RD_CMD      = 4'hB,
    parameter logic [3:0] WR_CMD      = 4'h2,
    parameter int         TIMEOUT     = 255
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic                              push,
    input  logic                              pull,
    input  logic [PA-$clog2(LINE_LENGTH)-1:0] tag,
    input  logic [3:0]                        dwrite,
    output logic                              rstrobe_d,
    output logic                              wstrobe_d,
    output logic [3:0]                        dread,
    output logic                              busy,
    output logic                              done,
    output logic                              err,
    output logic                              mem_sel,
    output logic                              mem_oe,
    output logic [3:0]                        mem_out,
    input  logic [3:0]                        mem_in,
    input  logic                              mem_rdy
);

    localparam int TW   = PA - $clog2(LINE_LENGTH);
    localparam int NA   = (TW + 3) / 4;
    localparam int AW   = NA * 4;
    localparam int NN   = 2 * LINE_LENGTH;
    localparam int CMX0 = (TIMEOUT > NN) ? TIMEOUT : NN;
    localparam int CMAX = (CMX0 > NA) ? CMX0 : NA;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0] NA_LAST  = CW'(NA - 1);
    localparam logic [CW-1:0] NIB_LAST = CW'(NN - 1);
    localparam logic [CW-1:0] NIB_CNT  = CW'(NN);
    localparam logic [CW-1:0] TO_CNT   = CW'(TIMEOUT);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [3:0] IDLE  = 4'd0;
    localparam logic [3:0] WCMD  = 4'd1;
    localparam logic [3:0] WADDR = 4'd2;
    localparam logic [3:0] WDATA = 4'd3;
    localparam logic [3:0] WGAP  = 4'd4;
    localparam logic [3:0] RCMD  = 4'd5;
    localparam logic [3:0] RADDR = 4'd6;
    localparam logic [3:0] RWAIT = 4'd7;
    localparam logic [3:0] RDATA = 4'd8;
    localparam logic [3:0] DONE  = 4'd9;

    logic [3:0]    state;
    logic [CW-1:0] cnt;
    logic [AW-1:0] addr_sr;   // zero-extended tag, shifted out MSB nibble first
    logic          dv;        // a read nibble is present on mem_in this cycle

    always_comb begin
        rstrobe_d = 1'b0;
        mem_sel   = 1'b0;
        mem_oe    = 1'b0;
        mem_out   = 4'h0;
        done      = 1'b0;
        err       = 1'b0;
        dv        = 1'b0;
        case (state)
            WCMD: begin
                mem_sel = 1'b1;
                mem_oe  = 1'b1;
                mem_out = WR_CMD;
            end
            WADDR, RADDR: begin
                mem_sel = 1'b1;
                mem_oe  = 1'b1;
                mem_out = addr_sr[AW-1 -: 4];
            end
            WDATA: begin
                // Cache data passes straight through so the strobe never gaps.
                mem_sel   = 1'b1;
                mem_oe    = 1'b1;
                rstrobe_d = 1'b1;
                mem_out   = dwrite;
            end
            RCMD: begin
                mem_sel = 1'b1;
                mem_oe  = 1'b1;
                mem_out = RD_CMD;
            end
            RWAIT: begin
                mem_sel = 1'b1;
                dv      = mem_rdy;
                err     = !mem_rdy && (cnt == TO_CNT);
            end
            RDATA: begin
                // cnt == NIB_CNT is the last cache-write cycle; the bus is already released.
                if (cnt != NIB_CNT) begin
                    mem_sel = 1'b1;
                    dv      = 1'b1;
                end
            end
            DONE: done = 1'b1;
            default: ;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            addr_sr   <= '0;
            wstrobe_d <= 1'b0;
            dread     <= 4'h0;
        end else begin
            wstrobe_d <= dv;
            dread     <= dv ? mem_in : 4'h0;
            case (state)
                IDLE: begin
                    if (start && pull) begin
                        addr_sr <= AW'(tag);
                        cnt     <= '0;
                        state   <= push ? WCMD : RCMD;
                    end
                end
                WCMD: begin
                    cnt   <= '0;
                    state <= WADDR;
                end
                WADDR: begin
                    addr_sr <= addr_sr << 4;
                    if (cnt == NA_LAST) begin
                        cnt   <= '0;
                        state <= WDATA;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                WDATA: begin
                    if (cnt == NIB_LAST) begin
                        cnt   <= '0;
                        state <= WGAP;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                WGAP: begin
                    // The cache presents the missing line's tag once the victim is out.
                    addr_sr <= AW'(tag);
                    state   <= RCMD;
                end
                RCMD: begin
                    cnt   <= '0;
                    state <= RADDR;
                end
                RADDR: begin
                    addr_sr <= addr_sr << 4;
                    if (cnt == NA_LAST) begin
                        cnt   <= '0;
                        state <= RWAIT;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                RWAIT: begin
                    if (mem_rdy) begin
                        cnt   <= CNT_ONE;   // nibble 0 sampled this edge
                        state <= RDATA;
                    end else if (cnt == TO_CNT) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                RDATA: begin
                    if (cnt == NIB_CNT) begin
                        cnt   <= '0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_fill.sv
// Purpose: directed self-checking bench for dcache_fill (fill, write-back, timeout, reset abort, idle start).
// Latency: cycle-exact checks of every bus/strobe cycle against hand-derived sequences.
// Backpressure: memory side modelled by mem_rdy/mem_in; cache offset modelled from rstrobe_d.
module tb_dcache_fill;

    localparam int LL = 4;
    localparam int PA = 22;
    localparam int TW = 20;
    localparam int NA = 5;
    localparam int NN = 8;
    localparam int TO = 255;

    logic          clk = 1'b0;
    logic          reset;
    logic          start, push, pull;
    logic [TW-1:0] tag;
    logic [3:0]    dwrite;
    logic          rstrobe_d, wstrobe_d;
    logic [3:0]    dread;
    logic          busy, done, err;
    logic          mem_sel, mem_oe;
    logic [3:0]    mem_out, mem_in;
    logic          mem_rdy;

    always #5 clk = ~clk;

    dcache_fill #(
        .LINE_LENGTH(LL), .PA(PA), .RD_CMD(4'hB), .WR_CMD(4'h2), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .push(push), .pull(pull), .tag(tag),
        .dwrite(dwrite), .rstrobe_d(rstrobe_d), .wstrobe_d(wstrobe_d), .dread(dread),
        .busy(busy), .done(done), .err(err), .mem_sel(mem_sel), .mem_oe(mem_oe),
        .mem_out(mem_out), .mem_in(mem_in), .mem_rdy(mem_rdy)
    );

    // Cache read-port model: offset advances on each strobed cycle, resets when the strobe drops.
    logic [3:0] off = 4'd0;
    always @(posedge clk) off <= rstrobe_d ? off + 4'd1 : 4'd0;
    assign dwrite = off + 4'd3;

    // busy, done, err, mem_sel, mem_oe, rstrobe_d, wstrobe_d
    wire [6:0] ctl = {busy, done, err, mem_sel, mem_oe, rstrobe_d, wstrobe_d};

    int nvec = 0;
    int nmis = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic launch(input logic p, input logic [TW-1:0] t);
        adv();
        start = 1'b1; pull = 1'b1; push = p; tag = t;
        smp();
        chk("launch idle ctl", 32'(ctl), 32'h0);
    endtask

    // From WCMD through WGAP; abort_at >= 0 asserts reset in that WDATA cycle.
    task automatic write_seq(input logic [TW-1:0] t, input logic [TW-1:0] t2, input int abort_at);
        adv(); smp();
        chk("wcmd ctl", 32'(ctl), 32'b1001100);
        chk("wcmd out", 32'(mem_out), 32'h2);
        for (int i = 0; i < NA; i++) begin
            adv(); smp();
            chk("waddr ctl", 32'(ctl), 32'b1001100);
            chk("waddr out", 32'(mem_out), 32'(t[(NA-1-i)*4 +: 4]));
        end
        for (int k = 0; k < NN; k++) begin
            adv();
            if (k == 0) tag = t2;
            smp();
            chk("wdata ctl", 32'(ctl), 32'b1001110);
            chk("wdata out", 32'(mem_out), 32'(k + 3));
            if (k == abort_at) begin
                reset = 1'b0;
                #1;
                chk("abort ctl", 32'(ctl), 32'h0);
                chk("abort out", 32'(mem_out), 32'h0);
                return;
            end
        end
        adv(); smp();
        chk("wgap ctl", 32'(ctl), 32'b1000000);
        chk("wgap out", 32'(mem_out), 32'h0);
    endtask

    task automatic rhdr(input logic [TW-1:0] t);
        adv(); smp();
        chk("rcmd ctl", 32'(ctl), 32'b1001100);
        chk("rcmd out", 32'(mem_out), 32'hB);
        for (int i = 0; i < NA; i++) begin
            adv(); smp();
            chk("raddr ctl", 32'(ctl), 32'b1001100);
            chk("raddr out", 32'(mem_out), 32'(t[(NA-1-i)*4 +: 4]));
        end
    endtask

    task automatic rbody(input int rdy_at, input logic [3:0] base);
        for (int w = 0; w <= rdy_at; w++) begin
            adv();
            mem_rdy = (w == rdy_at);
            mem_in  = (w == rdy_at) ? base : 4'h0;
            smp();
            chk("rwait ctl", 32'(ctl), 32'b1001000);
            chk("rwait out", 32'(mem_out), 32'h0);
        end
        for (int k = 1; k < NN; k++) begin
            adv();
            mem_rdy = 1'b0;
            mem_in  = 4'(base + 4'(k));
            smp();
            chk("rdata ctl", 32'(ctl), 32'b1001001);
            chk("rdata dread", 32'(dread), 32'(4'(base + 4'(k - 1))));
        end
        adv();
        mem_in = 4'h0;
        smp();
        chk("rlast ctl", 32'(ctl), 32'b1000001);
        chk("rlast dread", 32'(dread), 32'(4'(base + 4'd7)));
        adv(); smp();
        chk("done ctl", 32'(ctl), 32'b1100000);
        adv(); smp();
        chk("post-done ctl", 32'(ctl), 32'h0);
        start = 1'b0; pull = 1'b0; push = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; start = 1'b0; push = 1'b0; pull = 1'b0;
        tag = '0; mem_in = 4'h0; mem_rdy = 1'b0;
        #2;
        chk("reset ctl", 32'(ctl), 32'h0);
        chk("reset out", 32'(mem_out), 32'h0);
        chk("reset dread", 32'(dread), 32'h0);
        adv(); adv();
        reset = 1'b1;

        // 1: clean fill, data at wait cycle 3
        launch(1'b0, 20'h12345);
        rhdr(20'h12345);
        rbody(3, 4'h8);

        // 2: write-back then fill; tag changes during write-back and is re-latched for the read
        launch(1'b1, 20'h12345);
        write_seq(20'h12345, 20'hABCDE, -1);
        rhdr(20'hABCDE);
        rbody(3, 4'h8);

        // 3: read timeout, then a new start straight away
        launch(1'b0, 20'h00F0F);
        rhdr(20'h00F0F);
        for (int w = 0; w <= TO; w++) begin
            adv();
            mem_rdy = 1'b0;
            smp();
            chk("to err", 32'(err), (w == TO) ? 32'h1 : 32'h0);
            if (w == TO) chk("to ctl", 32'(ctl), 32'b1011000);
        end
        adv(); smp();
        chk("to idle ctl", 32'(ctl), 32'h0);
        rhdr(20'h00F0F);
        rbody(2, 4'h0);

        // 4: reset in the 4th WDATA cycle, then a full restart
        launch(1'b1, 20'h0BEEF);
        write_seq(20'h0BEEF, 20'h0BEEF, 3);
        adv();
        reset = 1'b1;
        smp();
        chk("rst release ctl", 32'(ctl), 32'h0);
        write_seq(20'h0BEEF, 20'h0BEEF, -1);
        rhdr(20'h0BEEF);
        rbody(1, 4'h3);

        // 5: start without pull is ignored
        adv();
        start = 1'b1; pull = 1'b0; push = 1'b1;
        for (int i = 0; i < 10; i++) begin
            smp();
            chk("nopull ctl", 32'(ctl), 32'h0);
            chk("nopull out", 32'(mem_out), 32'h0);
            adv();
        end
        start = 1'b0; push = 1'b0;

        // 6: mem_rdy on the first wait cycle
        launch(1'b0, 20'h5A5A5);
        rhdr(20'h5A5A5);
        rbody(0, 4'h6);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/dcache_fill.md
Name: dcache_fill

Overview:
- Memory-side line transfer engine for the data cache.
- Responds to the cache's miss outputs (push/pull/tag) and moves lines in both directions.
  - Write-back: pulls nibbles out of the cache on dwrite using rstrobe_d.
  - Fill: feeds nibbles into the cache on dread using wstrobe_d.
- Converts both transfers to a 4-bit serial command/address/data memory bus.
- Sits between the dcache and the external nibble-serial RAM interface.

Parameters:
LINE_LENGTH, 4, cache line length in bytes; a line is 2*LINE_LENGTH nibbles.
PA, 22, physical address width.
RD_CMD, 4'hB, command nibble for a line read.
WR_CMD, 4'h2, command nibble for a line write.
TIMEOUT, 255, maximum cycles to wait for mem_rdy during a read.

Ports:
clk  in  1  clock; all logic on rising edge.
reset  in  1  asynchronous, active-low reset.
start  in  1  level; CPU access stalled on a cache miss.
push  in  1  victim line is dirty and must be written back first.
pull  in  1  line must be fetched (cache miss).
tag  in  PA-clog2(LINE_LENGTH)  line address from the cache.
dwrite  in  4  cache nibble at the cache's current offset.
rstrobe_d  out  1  cache read strobe; cache advances its offset each strobed cycle.
wstrobe_d  out  1  cache write strobe; dread is written at the cache's current offset.
dread  out  4  fill nibble into the cache.
busy  out  1  transfer in progress.
done  out  1  one-cycle pulse when the fill completes.
err  out  1  one-cycle pulse on read timeout.
mem_sel  out  1  memory bus select.
mem_oe  out  1  block drives mem_out.
mem_out  out  4  command, address or data nibble to memory.
mem_in  in  4  data nibble from memory.
mem_rdy  in  1  memory marks the first read data nibble.

Behaviour:
- Reset (reset low, async): all outputs 0, state IDLE, counters 0.
- NA = ceil((PA-clog2(LINE_LENGTH))/4) address nibbles; tag zero-extended, sent MSB nibble first. Defaults: NA=5.
- IDLE -> WCMD when start&&pull&&push. IDLE -> RCMD when start&&pull&&!push. Inputs are sampled on the clock edge; start with pull=0 is ignored.
- tag is latched on the IDLE exit edge, and re-latched on entry to RCMD (after a write-back).
- WCMD: mem_sel=1, mem_oe=1, mem_out=WR_CMD.
- WADDR: NA cycles of address nibbles.
- WDATA: exactly 2*LINE_LENGTH consecutive cycles.
  - rstrobe_d=1.
  - mem_out=dwrite, combinational pass-through in the same cycle.
  - The cache offset resets whenever the strobe drops, so the strobe must never gap.
- WGAP: 1 cycle with mem_sel=0, then RCMD.
- RCMD: mem_out=RD_CMD. RADDR: NA address nibbles.
- RWAIT: mem_oe=0, mem_sel=1, wait counter from 0.
  - The cycle with mem_rdy=1 carries nibble 0 on mem_in.
  - Memory then supplies nibbles 1..2L-1 on consecutive cycles; mem_rdy is ignored after the first.
- RDATA:
  - dread and wstrobe_d are registered copies of mem_in and the data-valid flag.
  - Nibble k is written to the cache in cycle t+1+k, where t is the mem_rdy cycle.
  - wstrobe_d is high for exactly 2L contiguous cycles.
  - mem_sel drops after nibble 2L-1 is sampled.
- DONE: one cycle, done=1, start ignored; then IDLE. On the final strobe the cache marks the line valid, so pull falls.
- Timeout: wait counter reaches TIMEOUT in RWAIT with no mem_rdy.
  - err=1 for one cycle.
  - mem_sel=0, no wstrobe_d, done stays 0, return to IDLE.
  - A new start is accepted from the next cycle.
- busy=1 in every state except IDLE.
- mem_out=0 whenever mem_oe=0.
- Only reset can abort a transfer mid-way. An async reset mid-transfer drops all strobes and mem_sel immediately.
- push/pull/start changes after leaving IDLE are ignored.

Test Plan:
1. Clean fill, tag=20'h12345, push=0: mem_out sequence B,1,2,3,4,5. mem_rdy at wait cycle 3 with nibbles 0..7 = 8..F. Require wstrobe_d high 8 cycles with dread 8..F, done pulse 1 cycle later, busy low after.
2. Write-back + fill, push=1, dwrite model returns offset+3: mem_out = 2, 5 address nibbles, then 3,4,..,A. Require rstrobe_d high exactly 8 cycles, 1-cycle mem_sel gap, then read sequence as in 1.
3. Timeout, TIMEOUT=255, mem_rdy never asserted: err pulse on wait cycle 255. Require no wstrobe_d, done=0, mem_sel=0, IDLE; a new start then completes normally.
4. Reset (low) asserted at the 4th WDATA cycle: outputs 0 asynchronously. After release with start high, a full WCMD sequence restarts from the command nibble.
5. start=1, pull=0 for 10 cycles: no bus activity, busy=0. start held high through done: no re-trigger in the done cycle.
6. mem_rdy on the very first RWAIT cycle (t = RADDR end + 1): first wstrobe_d one cycle later. Require 8 contiguous strobes, no gaps.
